readout_deserializer: RTL and testbench

//  Column-parallel receiver for the pixel-array serial readout chains.
//  - Drives the shift-enable, samples every column's SerOutA/SerOutB bit each shift cycle.
//  - Rebuilds per-pixel A/B counter words and streams them out over a valid/ready port, one pixel per beat.
//  - Sits between the digital front-end array and the frame formatter.

---
 rtl/readout_deserializer_if.sv | 20 ++
 rtl/readout_deserializer.sv | 116 +++++++++++
 tb/tb_readout_deserializer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_deserializer_if.sv
// Pixel beat stream from readout_deserializer to the frame formatter.
// A beat transfers on a rising edge where pixValid && pixReady; while pixValid is high and pixReady low, the master holds every payload field stable.
interface readout_deserializer_if #(
  parameter int Row      = 2,
  parameter int Col      = 2,
  parameter int CntWidth = 8
) ();
  localparam int RowW = $clog2(Row);
  localparam int ColW = $clog2(Col);

  logic                pixValid;
  logic                pixReady;
  logic [RowW-1:0]     pixRow;
  logic [ColW-1:0]     pixCol;
  logic [CntWidth-1:0] pixCntA;
  logic [CntWidth-1:0] pixCntB;

  modport master (output pixValid, pixRow, pixCol, pixCntA, pixCntB, input pixReady);
  modport slave  (input pixValid, pixRow, pixCol, pixCntA, pixCntB, output pixReady);
endinterface

// File: rtl/readout_deserializer.sv
// Column-parallel deserializer for the pixel-array A/B readout chains; one pixel per beat.
// Optional macro READOUT_GRAY_DECODE_EN: counters arrive Gray-coded and are decoded on the output path.
module readout_deserializer #(
  parameter int Row      = 2,
  parameter int Col      = 2,
  parameter int CntWidth = 8
) (
  input  logic           readClk,
  input  logic           resetN,
  input  logic           start,
  input  logic           abort,
  input  logic [Col-1:0] serInA,
  input  logic [Col-1:0] serInB,
  output logic           shiftEn,
  output logic           busy,
  output logic           frameDone,
  output logic [1:0]     stateDbg,
  readout_deserializer_if.master pix
);
  localparam int RowW = $clog2(Row);
  localparam int ColW = $clog2(Col);
  localparam int BitW = $clog2(CntWidth);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [RowW-1:0] RowLast = RowW'(Row - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(Col - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(CntWidth - 1);

  logic [1:0]          state;
  logic [RowW-1:0]     rowIdx;
  logic [ColW-1:0]     colIdx;
  logic [BitW-1:0]     bitCnt;
  logic [CntWidth-1:0] shregA [Col];
  logic [CntWidth-1:0] shregB [Col];
  logic                drainActive;

  function automatic logic [CntWidth-1:0] decodeCnt(input logic [CntWidth-1:0] raw);
`ifdef READOUT_GRAY_DECODE_EN
    logic [CntWidth-1:0] bin;
    bin[CntWidth-1] = raw[CntWidth-1];
    for (int i = CntWidth - 2; i >= 0; i--) bin[i] = bin[i+1] ^ raw[i];
    return bin;
`else
    return raw;
`endif
  endfunction

  always_ff @(posedge readClk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      rowIdx <= '0;
      colIdx <= '0;
      bitCnt <= '0;
      for (int c = 0; c < Col; c++) begin
        shregA[c] <= '0;
        shregB[c] <= '0;
      end
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SHIFT;
            rowIdx <= '0;
            bitCnt <= '0;
          end
        end
        SHIFT: begin
          // MSB first: each bit pushes the previous ones toward the top.
          for (int c = 0; c < Col; c++) begin
            shregA[c] <= {shregA[c][CntWidth-2:0], serInA[c]};
            shregB[c] <= {shregB[c][CntWidth-2:0], serInB[c]};
          end
          bitCnt <= bitCnt + BitW'(1);
          if (bitCnt == BitLast) begin
            state  <= DRAIN;
            colIdx <= '0;
          end
        end
        DRAIN: begin
          if (pix.pixReady) begin
            if (colIdx != ColLast) begin
              colIdx <= colIdx + ColW'(1);
            end else if (rowIdx != RowLast) begin
              rowIdx <= rowIdx + RowW'(1);
              bitCnt <= '0;
              state  <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All status and beat outputs decode from state so reset clears them without a clock.
  assign drainActive  = (state == DRAIN);
  assign shiftEn      = (state == SHIFT);
  assign busy         = (state != IDLE);
  assign frameDone    = (state == DONE);
  assign stateDbg     = state;

  assign pix.pixValid = drainActive;
  assign pix.pixRow   = drainActive ? rowIdx : '0;
  assign pix.pixCol   = drainActive ? colIdx : '0;
  assign pix.pixCntA  = drainActive ? decodeCnt(shregA[colIdx]) : '0;
  assign pix.pixCntB  = drainActive ? decodeCnt(shregB[colIdx]) : '0;
endmodule

// File: tb/tb_readout_deserializer.sv
// Randomized scoreboard bench for readout_deserializer with a serial pixel-array model.
module tb_readout_deserializer;
  localparam int Row      = 2;
  localparam int Col      = 2;
  localparam int CntWidth = 8;
  localparam int RowW     = $clog2(Row);
  localparam int ColW     = $clog2(Col);
  localparam int BeatW    = RowW + ColW + 2 * CntWidth;
  localparam int ChainLen = Row * CntWidth;
  localparam int FrameLen = Row * (CntWidth + Col) + 2;

  logic           readClk = 1'b0;
  logic           resetN  = 1'b1;
  logic           start   = 1'b0;
  logic           abort   = 1'b0;
  logic [Col-1:0] serInA;
  logic [Col-1:0] serInB;
  logic           shiftEn;
  logic           busy;
  logic           frameDone;
  logic [1:0]     stateDbg;

  readout_deserializer_if #(.Row(Row), .Col(Col), .CntWidth(CntWidth)) pixIf ();

  readout_deserializer #(.Row(Row), .Col(Col), .CntWidth(CntWidth)) dut (
    .readClk   (readClk),
    .resetN    (resetN),
    .start     (start),
    .abort     (abort),
    .serInA    (serInA),
    .serInB    (serInB),
    .shiftEn   (shiftEn),
    .busy      (busy),
    .frameDone (frameDone),
    .stateDbg  (stateDbg),
    .pix       (pixIf)
  );

  // ---------------- clock ----------------
  always #5 readClk = ~readClk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BeatW-1:0] exp_q[$];

  int shiftCycles = 0;
  int frameDones  = 0;
  int beats       = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // ---------------- pixel array model ----------------
  logic [CntWidth-1:0] imgA [Col][Row];
  logic [CntWidth-1:0] imgB [Col][Row];
  int imgGen   = 0;
  int seenGen  = 0;
  int shiftPos = 0;

  always_comb begin
    serInA = '0;
    serInB = '0;
    if (shiftPos < ChainLen) begin
      for (int c = 0; c < Col; c++) begin
        serInA[c] = imgA[c][shiftPos / CntWidth][CntWidth - 1 - (shiftPos % CntWidth)];
        serInB[c] = imgB[c][shiftPos / CntWidth][CntWidth - 1 - (shiftPos % CntWidth)];
      end
    end
  end

  always @(posedge readClk) begin
    if (imgGen != seenGen) begin
      seenGen  <= imgGen;
      shiftPos <= 0;
    end else if (shiftEn) begin
      shiftPos <= shiftPos + 1;
    end
  end

  // Reference decode: binary value is the XOR of all right-shifts of the Gray word.
  function automatic logic [CntWidth-1:0] ref_cnt(input logic [CntWidth-1:0] g);
`ifdef READOUT_GRAY_DECODE_EN
    logic [CntWidth-1:0] b;
    b = '0;
    for (int k = 0; k < CntWidth; k++) b = b ^ (g >> k);
    return b;
`else
    return g;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_basic();
    imgA[0][0] = 8'hA5; imgA[0][1] = 8'h3C;
    imgA[1][0] = 8'h01; imgA[1][1] = 8'hFF;
    for (int c = 0; c < Col; c++)
      for (int r = 0; r < Row; r++) imgB[c][r] = ~imgA[c][r];
  endtask

  task automatic fill_random();
    for (int c = 0; c < Col; c++)
      for (int r = 0; r < Row; r++) begin
        imgA[c][r] = CntWidth'($urandom_range(0, 255));
        imgB[c][r] = CntWidth'($urandom_range(0, 255));
      end
  endtask

  task automatic push_and_load();
    imgGen++;
    for (int r = 0; r < Row; r++)
      for (int c = 0; c < Col; c++)
        exp_q.push_back({RowW'(r), ColW'(c), ref_cnt(imgA[c][r]), ref_cnt(imgB[c][r])});
  endtask

  task automatic start_pulse();
    @(posedge readClk); #1;
    start = 1'b1;
    @(posedge readClk); #1;
    start = 1'b0;
  endtask

  // readyMode: 0 always ready, 1 five-cycle stall on beat (0,1), 2 random ready.
  task automatic run_frame(input int readyMode, input bit doAbort, input bit noise,
                           output int len, output int firstValid);
    int t;
    int shifts;
    int stall;
    shifts = 0;
    stall = 5;
    firstValid = -1;
    pixIf.pixReady = 1'b1;
    start_pulse();
    t = 1;
    while (busy && t < 2000) begin
      if (pixIf.pixValid && firstValid < 0) firstValid = t;
      if (shiftEn) shifts++;
      case (readyMode)
        1: begin
          if (pixIf.pixValid && pixIf.pixRow == 0 && pixIf.pixCol == 1 && stall > 0) begin
            pixIf.pixReady = 1'b0;
            stall--;
          end else begin
            pixIf.pixReady = 1'b1;
          end
        end
        2:       pixIf.pixReady = ($urandom_range(0, 3) != 0);
        default: pixIf.pixReady = 1'b1;
      endcase
      start = noise && (frameDone || $urandom_range(0, 3) == 0);
      abort = doAbort && shiftEn && (shifts == CntWidth + 3);
      @(posedge readClk); #1;
      t++;
      if (abort) begin
        check("abort_busy", busy, 0);
        check("abort_valid", pixIf.pixValid, 0);
        abort = 1'b0;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got=%0d required<2000", t);
    end
    len = t;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [BeatW-1:0] got;
    logic [BeatW-1:0] held;
    logic [BeatW-1:0] want;
    bit prevHeld;
    bit lastXfer;
    prevHeld = 1'b0;
    lastXfer = 1'b0;
    held = '0;
    forever begin
      @(negedge readClk);
      got = {pixIf.pixRow, pixIf.pixCol, pixIf.pixCntA, pixIf.pixCntB};
      if (shiftEn) shiftCycles++;
      if (pixIf.pixValid && prevHeld) begin
        check("hold_stable", got, held);
        check("hold_no_shift", shiftEn, 0);
      end
      if (frameDone) begin
        frameDones++;
        check("done_after_last_beat", lastXfer, 1);
        check("done_queue_empty", exp_q.size(), 0);
      end
      if (pixIf.pixValid && pixIf.pixReady) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected got=%0h required=none", got);
        end else begin
          want = exp_q.pop_front();
          check("beat", got, want);
        end
      end
      prevHeld = pixIf.pixValid && !pixIf.pixReady;
      held     = got;
      lastXfer = pixIf.pixValid && pixIf.pixReady;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int len;
    int fv;
    int s0;
    int d0;
    int b0;
    pixIf.pixReady = 1'b0;

    #2 resetN = 1'b0;
    #1;
    check("rst_shiftEn", shiftEn, 0);
    check("rst_valid", pixIf.pixValid, 0);
    check("rst_busy", busy, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_state", stateDbg, 0);
    check("rst_cntA", pixIf.pixCntA, 0);
    repeat (2) @(posedge readClk);
    #1 resetN = 1'b1;

    // Basic frame, always ready.
    set_basic();
    push_and_load();
    s0 = shiftCycles; d0 = frameDones; b0 = beats;
    run_frame(0, 1'b0, 1'b0, len, fv);
    check("basic_len", len, FrameLen);
    check("basic_first_valid", fv, CntWidth + 1);
    check("basic_shift_cycles", shiftCycles - s0, Row * CntWidth);
    check("basic_done_count", frameDones - d0, 1);
    check("basic_beats", beats - b0, Row * Col);
    check("basic_queue_empty", exp_q.size(), 0);

    // Backpressure: five stalled cycles on beat (0,1).
    set_basic();
    push_and_load();
    s0 = shiftCycles; d0 = frameDones; b0 = beats;
    run_frame(1, 1'b0, 1'b0, len, fv);
    check("bp_len", len, FrameLen + 5);
    check("bp_shift_cycles", shiftCycles - s0, Row * CntWidth);
    check("bp_beats", beats - b0, Row * Col);
    check("bp_done_count", frameDones - d0, 1);

    // Abort in the third shift cycle of row 1, then a clean frame.
    set_basic();
    push_and_load();
    d0 = frameDones; b0 = beats;
    run_frame(0, 1'b1, 1'b0, len, fv);
    check("abort_pending_beats", exp_q.size(), Col);
    exp_q.delete();
    repeat (3) @(posedge readClk);
    #1;
    check("abort_no_done", frameDones - d0, 0);
    check("abort_state_idle", stateDbg, 0);
    check("abort_row0_beats", beats - b0, Col);
    set_basic();
    push_and_load();
    b0 = beats; d0 = frameDones;
    run_frame(0, 1'b0, 1'b0, len, fv);
    check("post_abort_beats", beats - b0, Row * Col);
    check("post_abort_done", frameDones - d0, 1);

    // Start pulses while busy (including during DONE) are ignored.
    fill_random();
    push_and_load();
    b0 = beats;
    run_frame(0, 1'b0, 1'b1, len, fv);
    check("noise_len", len, FrameLen);
    check("noise_beats", beats - b0, Row * Col);
    @(posedge readClk); #1;
    check("noise_stays_idle", busy, 0);

    // Gray boundary word 0x80 on both channels.
    fill_random();
    imgA[0][0] = 8'h80;
    imgB[1][1] = 8'h80;
    push_and_load();
    b0 = beats;
    run_frame(0, 1'b0, 1'b0, len, fv);
    check("gray_beats", beats - b0, Row * Col);

    // Asynchronous reset while a beat is stalled in DRAIN.
    fill_random();
    push_and_load();
    b0 = beats;
    start_pulse();
    pixIf.pixReady = 1'b0;
    for (int i = 0; i < 40 && !pixIf.pixValid; i++) begin
      @(posedge readClk); #1;
    end
    check("arst_reached_drain", pixIf.pixValid, 1);
    @(negedge readClk);
    #2 resetN = 1'b0;
    #1;
    check("arst_valid", pixIf.pixValid, 0);
    check("arst_shiftEn", shiftEn, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    @(posedge readClk); #1 resetN = 1'b1;
    @(posedge readClk); #1;
    check("arst_state_idle", stateDbg, 0);
    check("arst_no_beats", beats - b0, 0);

    // Randomized frames with random backpressure and start noise.
    for (int n = 0; n < 10; n++) begin
      fill_random();
      push_and_load();
      b0 = beats; d0 = frameDones;
      run_frame(2, 1'b0, 1'($urandom_range(0, 1)), len, fv);
      check("rand_beats", beats - b0, Row * Col);
      check("rand_done", frameDones - d0, 1);
      check("rand_queue_empty", exp_q.size(), 0);
    end

    repeat (2) @(posedge readClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
